control_unit: RTL
=================

# control_unit

Hardwired control sequencer for the single-bus datapath. It fetches each instruction through the datapath, decodes the opcode in IR[31:27], and steps through the execute micro-sequence one control step per clock. It drives the datapath's control inputs; before this block, a bench supplied those signals by hand. It sits beside `Datapath` in the CPU top level and replaces hand-driven control.

## Interface
- No parameters.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `clr`  in  1  reset, asynchronous, active-low.
- `ir`  in  32  IR contents from the datapath. Only `ir[31:27]` (opcode) is used.
- `con_in`  in  1  CON FF output from the datapath (branch condition).
- `run`  out  1  high while the processor is executing; low in HALT and reset.
- Control outputs, each 1 bit, active-high, 0 unless listed for the current step:
  - Bus-out drives: `pc_out`, `zlo_out`, `zhi_out`, `hi_out`, `lo_out`, `mdr_out`, `inport_out`, `r_out`, `ba_out`, `c_sign_extended_out`.
  - Register enables: `mar_enable`, `mdr_enable`, `z_enable`, `y_enable`, `pc_enable`, `ir_enable`, `hi_enable`, `lo_enable`, `outport_enable`, `con_enable`, `r_in`.
  - Register selects: `gra`, `grb`, `grc`.
  - Other: `read`, `ram_write`, `pc_increment`, `pc_init_enable`.

## Operation
- State register: RST, T0–T7, HALT. Outputs are a combinational decode of the state and the latched opcode, with no glitch-relevant feedback.
- The opcode is latched into an internal register on the T2→T3 edge. All execute steps use this copy.
- Fetch sequence:
  - RST: `pc_init_enable`=1. Next state T0.
  - T0: `pc_out`, `mar_enable`, `pc_increment`, `z_enable`.
  - T1: `zlo_out`, `pc_enable`, `read`, `mdr_enable`.
  - T2: `mdr_out`, `ir_enable`.
- Execute sequences. The last listed step always returns to T0.
  - ldi (00001), addi (01100):
    - T3: `grb`, `ba_out`, `y_enable`.
    - T4: `c_sign_extended_out`, `z_enable`.
    - T5: `zlo_out`, `gra`, `r_in`.
  - ld (00000):
    - T3–T4 as ldi.
    - T5: `zlo_out`, `mar_enable`.
    - T6: `read`, `mdr_enable`.
    - T7: `mdr_out`, `gra`, `r_in`.
  - st (00010):
    - T3–T5 as ld.
    - T6: `gra`, `r_out`, `mdr_enable` (`read`=0, so MDR loads from the bus).
    - T7: `ram_write`.
  - add/sub/and/or (00011/00100/00101/00110):
    - T3: `grb`, `r_out`, `y_enable`.
    - T4: `grc`, `r_out`, `z_enable`.
    - T5: `zlo_out`, `gra`, `r_in`.
  - brx (10010):
    - T3: `gra`, `r_out`, `con_enable`.
    - T4: `pc_out`, `y_enable`.
    - T5: `c_sign_extended_out`, `z_enable`.
    - T6: `zlo_out`; `pc_enable` only if `con_in`=1.
  - jr (10011): T3: `gra`, `r_out`, `pc_enable`.
  - in (10101): T3: `inport_out`, `gra`, `r_in`.
  - out (10110): T3: `gra`, `r_out`, `outport_enable`.
  - mfhi (10111): T3: `hi_out`, `gra`, `r_in`.
  - mflo (11000): T3: `lo_out`, `gra`, `r_in`.
  - nop (11001) and every unlisted opcode: T3 with all outputs 0, then T0.
  - halt (11010): T3 → HALT. HALT holds all outputs 0 and `run`=0 until `clr` is asserted.
- The ALU function is selected inside the datapath from IR. This block does not encode it.

## Timing
- Asynchronous reset: while `clr`=0, state=RST immediately. In RST, all outputs are 0 except `pc_init_enable`=1; `run`=0.
- First clock edge after `clr` rises: RST→T0, `run`=1. `run` stays 1 in T0–T7.
- One step per clock. Instruction length including fetch:
  - jr, in, out, mfhi, mflo, nop: 4 clocks.
  - ldi, addi, ALU ops: 6 clocks.
  - brx: 7 clocks.
  - ld, st: 8 clocks.
- `con_in` is sampled combinationally during T6 of brx. The CON FF was loaded at the T3→T4 edge.
- Reset mid-instruction aborts the sequence at once. No partial write completes after `clr` falls.
- `ram_write` and `read` are never high in the same step. `r_in` and `r_out` are never high together.
- Exactly one bus-out drive is high in any step that drives the bus.

## Test plan
- Reset release, then ir=0x0A000017 (ldi): T0–T5 outputs match the ldi list, then return to T0; opcode latch = 00001.
- ALU op, ir opcode 00011 (add): T3 asserts `grb`+`r_out`+`y_enable`; T4 asserts `grc`+`r_out`+`z_enable`; T5 asserts `gra`+`r_in`+`zlo_out`; total 6 clocks.
- brx with `con_in`=0, then with `con_in`=1: `pc_enable` is low in T6 for the first and high for the second; both return to T0 after 7 clocks.
- st (00010): `ram_write`=1 only in T7; `read`=0 throughout T6–T7; the next fetch starts on the 9th clock.
- halt (11010): HALT reached after T3, `run`=0 and outputs stay 0 for 20 clocks. `clr` pulse → RST with `pc_init_enable`=1, then T0.
- `clr` asserted in T6 of ld: all outputs go 0 and `pc_init_enable`=1 before the next edge. `r_in` is never asserted for the aborted load.

Source files
------------

// File: rtl/control_unit.sv
// Hardwired control sequencer for the single-bus datapath: fetches, decodes
// IR[31:27] and steps through each instruction's execute micro-sequence.
module control_unit (
    input  logic        clk,
    input  logic        clr,
    input  logic [31:0] ir,
    input  logic        con_in,
    output logic        run,
    output logic        pc_out,
    output logic        zlo_out,
    output logic        zhi_out,
    output logic        hi_out,
    output logic        lo_out,
    output logic        mdr_out,
    output logic        inport_out,
    output logic        r_out,
    output logic        ba_out,
    output logic        c_sign_extended_out,
    output logic        mar_enable,
    output logic        mdr_enable,
    output logic        z_enable,
    output logic        y_enable,
    output logic        pc_enable,
    output logic        ir_enable,
    output logic        hi_enable,
    output logic        lo_enable,
    output logic        outport_enable,
    output logic        con_enable,
    output logic        r_in,
    output logic        gra,
    output logic        grb,
    output logic        grc,
    output logic        read,
    output logic        ram_write,
    output logic        pc_increment,
    output logic        pc_init_enable
);

    typedef enum logic [3:0] {
        S_RST, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
    } state_t;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_BRX  = 5'b10010;
    localparam logic [4:0] OP_JR   = 5'b10011;
    localparam logic [4:0] OP_IN   = 5'b10101;
    localparam logic [4:0] OP_OUT  = 5'b10110;
    localparam logic [4:0] OP_MFHI = 5'b10111;
    localparam logic [4:0] OP_MFLO = 5'b11000;
    localparam logic [4:0] OP_HALT = 5'b11010;

    state_t     state, state_next;
    logic [4:0] opcode;
    logic       is_imm, is_mem, is_alu, is_brx, is_ld;
    logic       ir_unused;

    assign ir_unused = ^ir[26:0];

    assign is_imm = (opcode == OP_LDI) || (opcode == OP_ADDI);
    assign is_mem = (opcode == OP_LD) || (opcode == OP_ST);
    assign is_ld  = (opcode == OP_LD);
    assign is_alu = (opcode >= OP_ADD) && (opcode <= OP_OR);
    assign is_brx = (opcode == OP_BRX);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state  <= S_RST;
            opcode <= '0;
        end else begin
            state <= state_next;
            if (state == S_T2) opcode <= ir[31:27];
        end
    end

    always_comb begin
        state_next = S_RST;
        case (state)
            S_RST:  state_next = S_T0;
            S_T0:   state_next = S_T1;
            S_T1:   state_next = S_T2;
            S_T2:   state_next = S_T3;
            S_T3: begin
                if (opcode == OP_HALT)                        state_next = S_HALT;
                else if (is_imm || is_mem || is_alu || is_brx) state_next = S_T4;
                else                                          state_next = S_T0;
            end
            S_T4:   state_next = S_T5;
            S_T5:   state_next = (is_mem || is_brx) ? S_T6 : S_T0;
            S_T6:   state_next = is_mem ? S_T7 : S_T0;
            S_T7:   state_next = S_T0;
            S_HALT: state_next = S_HALT;
            default: state_next = S_RST;
        endcase
    end

    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        run = 1'b0;
        pc_out = 1'b0; zlo_out = 1'b0; zhi_out = 1'b0; hi_out = 1'b0; lo_out = 1'b0;
        mdr_out = 1'b0; inport_out = 1'b0; r_out = 1'b0; ba_out = 1'b0;
        c_sign_extended_out = 1'b0;
        mar_enable = 1'b0; mdr_enable = 1'b0; z_enable = 1'b0; y_enable = 1'b0;
        pc_enable = 1'b0; ir_enable = 1'b0; hi_enable = 1'b0; lo_enable = 1'b0;
        outport_enable = 1'b0; con_enable = 1'b0; r_in = 1'b0;
        gra = 1'b0; grb = 1'b0; grc = 1'b0;
        read = 1'b0; ram_write = 1'b0; pc_increment = 1'b0; pc_init_enable = 1'b0;

        run = (state != S_RST) && (state != S_HALT);
        case (state)
            S_RST: pc_init_enable = 1'b1;
            S_T0: begin pc_out = 1'b1; mar_enable = 1'b1; pc_increment = 1'b1; z_enable = 1'b1; end
            S_T1: begin zlo_out = 1'b1; pc_enable = 1'b1; read = 1'b1; mdr_enable = 1'b1; end
            S_T2: begin mdr_out = 1'b1; ir_enable = 1'b1; end
            S_T3: begin
                if (is_imm || is_mem) begin
                    grb = 1'b1; ba_out = 1'b1; y_enable = 1'b1;
                end else if (is_alu) begin
                    grb = 1'b1; r_out = 1'b1; y_enable = 1'b1;
                end else begin
                    case (opcode)
                        OP_BRX:  begin gra = 1'b1; r_out = 1'b1; con_enable = 1'b1; end
                        OP_JR:   begin gra = 1'b1; r_out = 1'b1; pc_enable = 1'b1; end
                        OP_IN:   begin inport_out = 1'b1; gra = 1'b1; r_in = 1'b1; end
                        OP_OUT:  begin gra = 1'b1; r_out = 1'b1; outport_enable = 1'b1; end
                        OP_MFHI: begin hi_out = 1'b1; gra = 1'b1; r_in = 1'b1; end
                        OP_MFLO: begin lo_out = 1'b1; gra = 1'b1; r_in = 1'b1; end
                        default: ;
                    endcase
                end
            end
            S_T4: begin
                if (is_imm || is_mem) begin
                    c_sign_extended_out = 1'b1; z_enable = 1'b1;
                end else if (is_alu) begin
                    grc = 1'b1; r_out = 1'b1; z_enable = 1'b1;
                end else if (is_brx) begin
                    pc_out = 1'b1; y_enable = 1'b1;
                end
            end
            S_T5: begin
                if (is_imm || is_alu) begin
                    zlo_out = 1'b1; gra = 1'b1; r_in = 1'b1;
                end else if (is_mem) begin
                    zlo_out = 1'b1; mar_enable = 1'b1;
                end else if (is_brx) begin
                    c_sign_extended_out = 1'b1; z_enable = 1'b1;
                end
            end
            S_T6: begin
                if (is_ld) begin
                    read = 1'b1; mdr_enable = 1'b1;
                end else if (is_mem) begin
                    // store: MDR loads the source register from the bus since read is low
                    gra = 1'b1; r_out = 1'b1; mdr_enable = 1'b1;
                end else if (is_brx) begin
                    zlo_out = 1'b1; pc_enable = con_in;
                end
            end
            S_T7: begin
                if (is_ld) begin
                    mdr_out = 1'b1; gra = 1'b1; r_in = 1'b1;
                end else if (is_mem) begin
                    ram_write = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule
